key_state_tracker: RTL and testbench
====================================

KEY_STATE_TRACKER -- requirements
Module: key_state_tracker

Interface
REQ-001 SHALL have parameter NUM_KEYS, default 6: number of tracked key channels, 1..16.
REQ-002 SHALL have parameter CODE_TABLE, NUM_KEYS*8 bits, default {8'h7A,8'h72,8'h69,8'h74,8'h73,8'h6B}: scan code of channel i at bits [8i+7:8i].
REQ-003 SHALL have parameter HOLD_WIDTH, default 16: width of each per-channel hold-time counter.
REQ-004 SHALL have parameter TICK_DIV, default 50000: clk cycles per hold tick (1 ms at 50 MHz), >= 2.
REQ-005 SHALL have port clk  input  1  system clock (CLOCK_50); all state updates on its rising edge.
REQ-006 SHALL have port resetn  input  1  asynchronous active-low reset.
REQ-007 SHALL have port valid  input  1  decoder event strobe; level may persist for several cycles.
REQ-008 SHALL have port make_break  input  1  1 = make (press), 0 = break (release); sampled with out_code.
REQ-009 SHALL have port out_code  input  8  scan code of the event.
REQ-010 SHALL have port clear  input  1  synchronous request to drop all keys to released.
REQ-011 SHALL have port key_down  output  NUM_KEYS  registered held state per channel.
REQ-012 SHALL have port key_pressed  output  NUM_KEYS  one-cycle pulse on channel's released->held transition.
REQ-013 SHALL have port key_released  output  NUM_KEYS  one-cycle pulse on channel's held->released transition.
REQ-014 SHALL have port hold_time  output  NUM_KEYS*HOLD_WIDTH  channel i at [HOLD_WIDTH*i+HOLD_WIDTH-1:HOLD_WIDTH*i], in ticks.
REQ-015 SHALL have port any_down  output  1  OR of key_down.
REQ-016 SHALL have port down_count  output  5  number of channels currently held.

Function
REQ-017 SHALL register valid into valid_q each cycle; an event SHALL be accepted only on the edge where valid=1 and valid_q=0 (one event per strobe, regardless of strobe length).
REQ-018 SHALL, on an accepted make event, set key_down[i] for every channel i whose CODE_TABLE entry equals out_code; on accepted break, clear it; duplicate table entries SHALL all update.
REQ-019 SHALL ignore accepted events whose out_code matches no channel (no output change).
REQ-020 SHALL update key_down on the accepting edge and assert key_pressed/key_released for exactly the following cycle (latency 1 clk from the accepting edge).
REQ-021 SHALL NOT pulse key_pressed on a make for an already-held channel (typematic repeat), nor key_released on a break for an already-released channel.
REQ-022 SHALL run a free tick counter 0..TICK_DIV-1 from reset, issuing a one-cycle tick when it wraps to 0.
REQ-023 SHALL zero hold_time[i] on the edge channel i becomes held; SHALL increment it by 1 on each tick while held; SHALL saturate at 2^HOLD_WIDTH-1.
REQ-024 SHALL freeze hold_time[i] while released, keeping the last duration readable until the next press.
REQ-025 SHALL, when a press and a tick coincide on one channel, zero the counter (press wins).
REQ-026 SHALL, when clear=1, release all held channels on that edge, pulsing key_released for each channel that was held; clear SHALL override an event accepted on the same edge, and the event SHALL be discarded.
REQ-027 SHALL derive any_down and down_count combinationally from registered key_down.

Reset
REQ-028 SHALL, while resetn=0, force key_down, key_pressed, key_released, hold_time, tick counter, valid_q to 0; any_down=0, down_count=0.
REQ-029 SHALL, with valid=1 held across reset release, NOT accept an event until valid falls and rises again... except valid_q resets to 0, so the first edge after release with valid=1 SHALL be accepted as one event.
REQ-030 SHALL, on reset mid-hold, abandon all holds without release pulses.

Verification
REQ-031 Make 8'h6B, valid high 3 cycles -> key_down=6'b000001 after 1 edge, key_pressed[0] one cycle only, down_count=1.
REQ-032 Make 8'h73 twice, then break 8'h73 -> one key_pressed[1] pulse, one key_released[1] pulse, key_down[1]=0.
REQ-033 Hold 8'h7A for 5*TICK_DIV cycles (TICK_DIV=4 in bench), release -> hold_time[5] reads 5 (+/-1) and stays after release; HOLD_WIDTH=3, hold 20 ticks -> saturates at 7.
REQ-034 Hold 8'h6B and 8'h74, assert clear with a concurrent make 8'h72 -> key_released pulses on bits 0 and 2, key_down=0, channel 4 stays released.
REQ-035 Break 8'h69 while released and make 8'h1C (unmapped) -> all outputs unchanged.
REQ-036 Drop resetn during a hold -> all outputs 0 immediately (async), no key_released pulse.

Source files
------------

// File: rtl/key_state_tracker.sv
// Tracks held/released state of scan-code mapped keys from a make/break decoder,
// with press/release pulses and per-channel hold-time counters in tick units.
module key_state_tracker #(
    parameter int unsigned             NUM_KEYS   = 6,
    parameter logic [NUM_KEYS*8-1:0]   CODE_TABLE = {8'h7A, 8'h72, 8'h69, 8'h74, 8'h73, 8'h6B},
    parameter int unsigned             HOLD_WIDTH = 16,
    parameter int unsigned             TICK_DIV   = 50000
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic                           valid,
    input  logic                           make_break,
    input  logic [7:0]                     out_code,
    input  logic                           clear,
    output logic [NUM_KEYS-1:0]            key_down,
    output logic [NUM_KEYS-1:0]            key_pressed,
    output logic [NUM_KEYS-1:0]            key_released,
    output logic [NUM_KEYS*HOLD_WIDTH-1:0] hold_time,
    output logic                           any_down,
    output logic [4:0]                     down_count
);

    localparam int unsigned     TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0]   TICK_LAST = TW'(TICK_DIV - 1);

    logic                r_valid_q;
    logic [NUM_KEYS-1:0] r_key_down;
    logic [NUM_KEYS-1:0] r_key_pressed;
    logic [NUM_KEYS-1:0] r_key_released;
    logic [TW-1:0]       r_tick_cnt;

    logic                w_accept;
    logic                w_tick;
    logic [NUM_KEYS-1:0] w_match;
    logic [NUM_KEYS-1:0] w_next_down;
    logic [NUM_KEYS-1:0] w_rise;
    logic [4:0]          w_down_count;

    assign w_accept = valid & ~r_valid_q;
    assign w_tick   = (r_tick_cnt == TICK_LAST);

    always_comb begin
        w_match = '0;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            w_match[i] = (CODE_TABLE[8*i +: 8] == out_code);
        end
    end

    // Clear takes priority and discards any event accepted on the same edge.
    always_comb begin
        w_next_down = r_key_down;
        if (clear) begin
            w_next_down = '0;
        end else if (w_accept) begin
            if (make_break) begin
                w_next_down = r_key_down | w_match;
            end else begin
                w_next_down = r_key_down & ~w_match;
            end
        end
    end

    assign w_rise = w_next_down & ~r_key_down;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_valid_q      <= 1'b0;
            r_key_down     <= '0;
            r_key_pressed  <= '0;
            r_key_released <= '0;
        end else begin
            r_valid_q      <= valid;
            r_key_down     <= w_next_down;
            r_key_pressed  <= w_rise;
            r_key_released <= r_key_down & ~w_next_down;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + TW'(1);
        end
    end

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_chan
        logic [HOLD_WIDTH-1:0] r_hold;

        // A press zeroes the count even if a tick lands on the same edge.
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                r_hold <= '0;
            end else if (w_rise[g]) begin
                r_hold <= '0;
            end else if (r_key_down[g] && w_tick && (r_hold != '1)) begin
                r_hold <= r_hold + HOLD_WIDTH'(1);
            end
        end

        assign hold_time[g*HOLD_WIDTH +: HOLD_WIDTH] = r_hold;
    end

    always_comb begin
        w_down_count = '0;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            w_down_count = w_down_count + 5'(r_key_down[i]);
        end
    end

    assign key_down     = r_key_down;
    assign key_pressed  = r_key_pressed;
    assign key_released = r_key_released;
    assign any_down     = |r_key_down;
    assign down_count   = w_down_count;

endmodule

// File: tb/tb_key_state_tracker.sv
// Scoreboard bench for key_state_tracker: a reference key-state model queues
// expected outputs per event, which are popped and compared after the accepting edge.
module tb_key_state_tracker;

    typedef struct {
        logic [5:0] down;
        logic [5:0] pressed;
        logic [5:0] released;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        valid = 1'b0;
    logic        make_break = 1'b0;
    logic [7:0]  out_code = 8'h00;
    logic        clear = 1'b0;

    logic [5:0]  key_down, key_pressed, key_released;
    logic [95:0] hold_time;
    logic        any_down;
    logic [4:0]  down_count;

    logic [5:0]  s_key_down, s_key_pressed, s_key_released;
    logic [17:0] s_hold_time;
    logic        s_any_down;
    logic [4:0]  s_down_count;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [7:0]  code_tbl [6] = '{8'h6B, 8'h73, 8'h74, 8'h69, 8'h72, 8'h7A};
    logic [5:0]  m_down = '0;
    exp_t        sb_q [$];

    always #5 clk = ~clk;

    key_state_tracker #(.NUM_KEYS(6), .HOLD_WIDTH(16), .TICK_DIV(4)) dut (
        .clk(clk), .resetn(resetn), .valid(valid), .make_break(make_break),
        .out_code(out_code), .clear(clear), .key_down(key_down),
        .key_pressed(key_pressed), .key_released(key_released),
        .hold_time(hold_time), .any_down(any_down), .down_count(down_count)
    );

    key_state_tracker #(.NUM_KEYS(6), .HOLD_WIDTH(3), .TICK_DIV(4)) dut_sat (
        .clk(clk), .resetn(resetn), .valid(valid), .make_break(make_break),
        .out_code(out_code), .clear(clear), .key_down(s_key_down),
        .key_pressed(s_key_pressed), .key_released(s_key_released),
        .hold_time(s_hold_time), .any_down(s_any_down), .down_count(s_down_count)
    );

    task automatic send_event(input logic mk, input logic [7:0] code,
                              input int unsigned len, input logic clr);
        logic [5:0] match;
        logic [5:0] nxt;
        exp_t       e;
        match = '0;
        for (int i = 0; i < 6; i++) if (code_tbl[i] == code) match[i] = 1'b1;
        if (clr)     nxt = '0;
        else if (mk) nxt = m_down | match;
        else         nxt = m_down & ~match;
        e.down = nxt;
        e.pressed = nxt & ~m_down;
        e.released = m_down & ~nxt;
        sb_q.push_back(e);
        m_down = nxt;

        @(negedge clk);
        valid = 1'b1; make_break = mk; out_code = code; clear = clr;
        @(posedge clk); #1;
        clear = 1'b0;
        e = sb_q.pop_front();
        n_checks++;
        if (key_down !== e.down) begin
            n_errors++;
            $display("FAIL ev_key_down code=%h: got %b expected %b", code, key_down, e.down);
        end
        n_checks++;
        if (key_pressed !== e.pressed) begin
            n_errors++;
            $display("FAIL ev_key_pressed code=%h: got %b expected %b", code, key_pressed, e.pressed);
        end
        n_checks++;
        if (key_released !== e.released) begin
            n_errors++;
            $display("FAIL ev_key_released code=%h: got %b expected %b", code, key_released, e.released);
        end
        n_checks++;
        if (down_count !== 5'($countones(e.down)) || any_down !== (|e.down)) begin
            n_errors++;
            $display("FAIL ev_count code=%h: got cnt=%0d any=%b expected cnt=%0d any=%b",
                     code, down_count, any_down, $countones(e.down), |e.down);
        end
        for (int unsigned c = 1; c < len; c++) begin
            @(posedge clk); #1;
            n_checks++;
            if (key_pressed !== 6'b0 || key_released !== 6'b0 || key_down !== m_down) begin
                n_errors++;
                $display("FAIL strobe_hold code=%h cyc=%0d: got down=%b p=%b r=%b expected down=%b p=0 r=0",
                         code, c, key_down, key_pressed, key_released, m_down);
            end
        end
        @(negedge clk);
        valid = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (key_pressed !== 6'b0 || key_released !== 6'b0) begin
            n_errors++;
            $display("FAIL pulse_width code=%h: got p=%b r=%b expected 0", code, key_pressed, key_released);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (key_down !== 6'b0 || key_pressed !== 6'b0 || key_released !== 6'b0 ||
            hold_time !== 96'b0 || any_down !== 1'b0 || down_count !== 5'd0) begin
            n_errors++;
            $display("FAIL reset_state: got down=%b p=%b r=%b hold=%h any=%b cnt=%0d expected all 0",
                     key_down, key_pressed, key_released, hold_time, any_down, down_count);
        end
        @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_make_strobe();
        send_event(1'b1, 8'h6B, 3, 1'b0);
        send_event(1'b0, 8'h6B, 1, 1'b0);
    endtask

    task automatic test_typematic();
        send_event(1'b1, 8'h73, 1, 1'b0);
        send_event(1'b1, 8'h73, 2, 1'b0);
        send_event(1'b0, 8'h73, 1, 1'b0);
        send_event(1'b0, 8'h73, 1, 1'b0);
    endtask

    task automatic test_hold_time();
        logic [15:0] h;
        send_event(1'b1, 8'h7A, 1, 1'b0);
        repeat (18) @(posedge clk);
        send_event(1'b0, 8'h7A, 1, 1'b0);
        h = hold_time[5*16 +: 16];
        n_checks++;
        if (h < 16'd4 || h > 16'd6) begin
            n_errors++;
            $display("FAIL hold_after_release: got %0d expected 5 (+/-1)", h);
        end
        repeat (12) @(posedge clk);
        #1;
        h = hold_time[5*16 +: 16];
        n_checks++;
        if (h < 16'd4 || h > 16'd6) begin
            n_errors++;
            $display("FAIL hold_frozen: got %0d expected 5 (+/-1)", h);
        end
        send_event(1'b1, 8'h7A, 1, 1'b0);
        n_checks++;
        if (hold_time[5*16 +: 16] > 16'd1) begin
            n_errors++;
            $display("FAIL hold_repress_zero: got %0d expected 0 or 1", hold_time[5*16 +: 16]);
        end
        send_event(1'b0, 8'h7A, 1, 1'b0);
    endtask

    task automatic test_saturation();
        send_event(1'b1, 8'h7A, 1, 1'b0);
        repeat (79) @(posedge clk);
        #1;
        n_checks++;
        if (s_hold_time[15 +: 3] !== 3'd7) begin
            n_errors++;
            $display("FAIL hold_saturate: got %0d expected 7", s_hold_time[15 +: 3]);
        end
        n_checks++;
        if (hold_time[5*16 +: 16] < 16'd19 || hold_time[5*16 +: 16] > 16'd21) begin
            n_errors++;
            $display("FAIL hold_long: got %0d expected 20 (+/-1)", hold_time[5*16 +: 16]);
        end
        send_event(1'b0, 8'h7A, 1, 1'b0);
    endtask

    task automatic test_clear();
        send_event(1'b1, 8'h6B, 1, 1'b0);
        send_event(1'b1, 8'h74, 1, 1'b0);
        send_event(1'b1, 8'h72, 1, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (key_down !== 6'b0) begin
            n_errors++;
            $display("FAIL clear_stays: got %b expected 000000", key_down);
        end
    endtask

    task automatic test_unmapped();
        send_event(1'b0, 8'h69, 1, 1'b0);
        send_event(1'b1, 8'h1C, 2, 1'b0);
    endtask

    task automatic test_reset_mid_hold();
        exp_t e;
        send_event(1'b1, 8'h6B, 1, 1'b0);
        repeat (6) @(posedge clk);
        @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        n_checks++;
        if (key_down !== 6'b0 || key_pressed !== 6'b0 || key_released !== 6'b0 ||
            hold_time !== 96'b0 || any_down !== 1'b0 || down_count !== 5'd0) begin
            n_errors++;
            $display("FAIL async_reset: got down=%b p=%b r=%b hold=%h any=%b cnt=%0d expected all 0",
                     key_down, key_pressed, key_released, hold_time, any_down, down_count);
        end
        m_down = '0;
        valid = 1'b1; make_break = 1'b1; out_code = 8'h6B;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (key_released !== 6'b0 || key_down !== 6'b0) begin
            n_errors++;
            $display("FAIL reset_no_release: got down=%b r=%b expected 0", key_down, key_released);
        end
        e.down = 6'b000001; e.pressed = 6'b000001; e.released = 6'b0;
        sb_q.push_back(e);
        m_down = 6'b000001;
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;
        e = sb_q.pop_front();
        n_checks++;
        if (key_down !== e.down || key_pressed !== e.pressed) begin
            n_errors++;
            $display("FAIL valid_across_reset: got down=%b p=%b expected down=%b p=%b",
                     key_down, key_pressed, e.down, e.pressed);
        end
        @(negedge clk);
        valid = 1'b0;
        send_event(1'b0, 8'h6B, 1, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_make_strobe();
        test_typematic();
        test_hold_time();
        test_saturation();
        test_clear();
        test_unmapped();
        test_reset_mid_hold();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
